// File: rtl/stream_pkg.sv
// Shared state encoding and width helpers for the batched-stream receiver.
package stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        REPORT = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Beat counter must hold BATCH_SIZE-1 without wrapping.
    function automatic int cnt_width(input int batch_size);
        return $clog2(batch_size + 1);
    endfunction

    function automatic int sum_width(input int data_width, input int batch_size);
        return data_width + $clog2(batch_size) + 1;
    endfunction

endpackage

// File: rtl/batch_stats.sv
// Running signed sum and peak-magnitude accumulator for one batch.
// sum_d_o/peak_d_o expose the post-update values so the caller can capture a finished batch.
module batch_stats
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int BATCH_SIZE = 2048
) (
    input  logic                                             clk_i,
    input  logic                                             rst_ni,
    input  logic                                             clear_i,
    input  logic                                             load_i,
    input  logic                                             acc_i,
    input  logic signed [DATA_WIDTH-1:0]                     data_i,
    output logic signed [sum_width(DATA_WIDTH, BATCH_SIZE)-1:0] sum_d_o,
    output logic        [DATA_WIDTH-1:0]                     peak_d_o
);

    localparam int SW = sum_width(DATA_WIDTH, BATCH_SIZE);

    logic signed [SW-1:0]         sum_q;
    logic        [DATA_WIDTH-1:0] peak_q;
    logic signed [SW-1:0]         data_sx;
    logic signed [DATA_WIDTH:0]   data_ext;
    logic        [DATA_WIDTH-1:0] abs_val;

    assign data_sx  = SW'(data_i);
    assign data_ext = {data_i[DATA_WIDTH-1], data_i};
    // Negating one bit wider makes the most negative sample map onto 2^(DATA_WIDTH-1).
    assign abs_val  = data_i[DATA_WIDTH-1] ? DATA_WIDTH'(-data_ext) : $unsigned(data_i);

    always_comb begin
        sum_d_o  = sum_q;
        peak_d_o = peak_q;
        if (clear_i) begin
            sum_d_o  = '0;
            peak_d_o = '0;
        end else if (load_i) begin
            sum_d_o  = data_sx;
            peak_d_o = abs_val;
        end else if (acc_i) begin
            sum_d_o  = sum_q + data_sx;
            peak_d_o = (abs_val > peak_q) ? abs_val : peak_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q  <= '0;
            peak_q <= '0;
        end else begin
            sum_q  <= sum_d_o;
            peak_q <= peak_d_o;
        end
    end

endmodule

// File: rtl/batch_receiver.sv
// Avalon-ST sink that checks BATCH_SIZE framing, reports per-batch sum/peak,
// and stops accepting data after RUNS good batches until restarted.
module batch_receiver
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int BATCH_SIZE = 2048,
    parameter int RUNS       = 3
) (
    input  logic                                          sink_clk,
    input  logic                                          reset_n,
    input  logic                                          sink_valid,
    input  logic                                          sink_sop,
    input  logic                                          sink_eop,
    input  logic signed [DATA_WIDTH-1:0]                  sink_data,
    output logic                                          sink_ready,
    input  logic                                          restart,
    output logic                                          batch_done,
    output logic signed [DATA_WIDTH+$clog2(BATCH_SIZE):0] batch_sum,
    output logic        [DATA_WIDTH-1:0]                  batch_peak,
    output logic        [$clog2(RUNS+1)-1:0]              batch_index,
    output logic                                          frame_error,
    output logic                                          run_done
);

    localparam int CW = cnt_width(BATCH_SIZE);
    localparam int SW = sum_width(DATA_WIDTH, BATCH_SIZE);
    localparam int IW = $clog2(RUNS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(BATCH_SIZE - 1);
    localparam logic [IW-1:0] RUNS_IDX = IW'(RUNS);

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    err_q, err_d;
    logic signed [SW-1:0]    sum_out_q, sum_out_d;
    logic [DATA_WIDTH-1:0]   peak_out_q, peak_out_d;

    logic                    beat;
    logic                    st_clear, st_load, st_acc;
    logic signed [SW-1:0]    st_sum;
    logic [DATA_WIDTH-1:0]   st_peak;

    assign sink_ready  = reset_n && ((state_q == IDLE) || (state_q == RECV));
    assign beat        = sink_valid && sink_ready;
    assign batch_done  = (state_q == REPORT);
    assign run_done    = (state_q == DONE);
    assign batch_sum   = sum_out_q;
    assign batch_peak  = peak_out_q;
    assign batch_index = idx_q;
    assign frame_error = err_q;

    batch_stats #(
        .DATA_WIDTH (DATA_WIDTH),
        .BATCH_SIZE (BATCH_SIZE)
    ) u_stats (
        .clk_i    (sink_clk),
        .rst_ni   (reset_n),
        .clear_i  (st_clear),
        .load_i   (st_load),
        .acc_i    (st_acc),
        .data_i   (sink_data),
        .sum_d_o  (st_sum),
        .peak_d_o (st_peak)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        err_d      = err_q;
        sum_out_d  = sum_out_q;
        peak_out_d = peak_out_q;
        st_clear   = 1'b0;
        st_load    = 1'b0;
        st_acc     = 1'b0;

        if (restart) begin
            // Restart wins over any beat presented in the same cycle.
            state_d    = IDLE;
            cnt_d      = '0;
            idx_d      = '0;
            err_d      = 1'b0;
            sum_out_d  = '0;
            peak_out_d = '0;
            st_clear   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (beat) begin
                        if (sink_sop && !sink_eop) begin
                            st_load = 1'b1;
                            cnt_d   = CW'(1);
                            state_d = RECV;
                        end else if (sink_sop && sink_eop && (BATCH_SIZE == 1)) begin
                            st_load    = 1'b1;
                            sum_out_d  = st_sum;
                            peak_out_d = st_peak;
                            idx_d      = idx_q + IW'(1);
                            state_d    = REPORT;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (beat) begin
                        if (sink_sop && !sink_eop) begin
                            err_d   = 1'b1;
                            st_load = 1'b1;
                            cnt_d   = CW'(1);
                        end else if (sink_sop || (sink_eop && cnt_q != LAST_CNT)
                                     || (!sink_eop && cnt_q == LAST_CNT)) begin
                            err_d    = 1'b1;
                            st_clear = 1'b1;
                            cnt_d    = '0;
                            state_d  = IDLE;
                        end else if (sink_eop) begin
                            st_acc     = 1'b1;
                            sum_out_d  = st_sum;
                            peak_out_d = st_peak;
                            idx_d      = idx_q + IW'(1);
                            cnt_d      = '0;
                            state_d    = REPORT;
                        end else begin
                            st_acc = 1'b1;
                            cnt_d  = cnt_q + CW'(1);
                        end
                    end
                end
                REPORT: begin
                    state_d = (idx_q == RUNS_IDX) ? DONE : IDLE;
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sink_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            sum_out_q  <= '0;
            peak_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            sum_out_q  <= sum_out_d;
            peak_out_q <= peak_out_d;
        end
    end

endmodule

// File: doc/batch_receiver.md
Name: batch_receiver

Overview:
- Avalon-ST sink that consumes the batched sample stream a time-buffer source emits (sop/eop/valid/data with ready backpressure, ready latency 0).
- Checks packet framing against BATCH_SIZE and computes per-batch signed sum and peak magnitude.
- Reports each completed batch and stops accepting data after RUNS good batches until restarted.
- Sits downstream of the buffer as the stream consumer and self-check point.

Parameters:
- DATA_WIDTH, 14, sample width; samples are two's complement.
- BATCH_SIZE, 2048, beats per packet; legal range 1..65536.
- RUNS, 3, good batches accepted before run_done.

Ports:
- sink_clk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- sink_valid  in  1  beat qualifier.
- sink_sop  in  1  first beat of packet.
- sink_eop  in  1  last beat of packet.
- sink_data  in  DATA_WIDTH  signed sample.
- sink_ready  out  1  receiver accepts a beat this cycle.
- restart  in  1  synchronous pulse that starts a new run.
- batch_done  out  1  one-cycle pulse when a good batch completes.
- batch_sum  out  DATA_WIDTH+$clog2(BATCH_SIZE)+1  signed sum of the batch.
- batch_peak  out  DATA_WIDTH  unsigned max |sample| of the batch.
- batch_index  out  $clog2(RUNS+1)  good batches completed in this run.
- frame_error  out  1  sticky flag; cleared by reset or restart.
- run_done  out  1  high once RUNS good batches have completed.

Behaviour:
- Beat definition: beat = sink_valid && sink_ready. sink_sop, sink_eop and sink_data are ignored unless a beat occurs.
- Reset (async assert, sync release):
  - All outputs 0; accumulators and beat counter 0; state IDLE.
  - sink_ready is forced 0 while reset_n is low.
- sink_ready is decoded from state: 1 in IDLE and RECV, 0 in REPORT and DONE.
- IDLE:
  - Beat with sop, no eop -> load sum=data, peak=|data|, cnt=1, go to RECV.
  - Beat with sop and eop -> complete batch if BATCH_SIZE==1, else set frame_error and stay in IDLE.
  - Beat without sop -> discard, set frame_error.
- RECV:
  - Normal beat: sum+=data, peak=max(peak,|data|), cnt++.
  - Beat with sop -> set frame_error, discard partial batch, restart accumulation with this beat as first (cnt=1).
  - Beat with eop and cnt==BATCH_SIZE-1 -> accumulate, go to REPORT.
  - Beat with eop and cnt!=BATCH_SIZE-1 -> set frame_error, discard, go to IDLE.
  - Beat with cnt==BATCH_SIZE-1 and no eop -> set frame_error, discard, go to IDLE. Following non-sop beats are then flagged by the IDLE rule.
- REPORT (exactly 1 cycle):
  - batch_done=1; batch_sum/batch_peak are registered and valid from this cycle; batch_index increments.
  - Next state is DONE if the new index==RUNS, else IDLE.
  - Latency: batch_done is high in the cycle after the eop beat.
- DONE: run_done=1, sink_ready=0, held until restart.
- Output hold: batch_sum, batch_peak and batch_index hold their values until the next REPORT, restart or reset.
- Restart:
  - restart=1 in any state -> next cycle state IDLE, batch_index=0, frame_error=0, run_done=0, accumulators cleared.
  - Any partial batch is discarded with no error.
  - restart takes priority over a simultaneous beat, and that beat is dropped. sink_ready must still be high that cycle per the state decode; the bench avoids driving a beat alongside restart.
- Arithmetic:
  - |x| is computed at DATA_WIDTH+1 then truncated to DATA_WIDTH unsigned, so -2^(DATA_WIDTH-1) gives exactly 2^(DATA_WIDTH-1).
  - The sum is sign-extended on each add; its width guarantees no overflow.
- Counter: the beat counter is $clog2(BATCH_SIZE+1) bits and never wraps in legal operation.

Decomposition:
- Shared package stream_pkg holds:
  - the state enum (IDLE, RECV, REPORT, DONE);
  - functions cnt_width(BATCH_SIZE) and sum_width(DATA_WIDTH, BATCH_SIZE).
- One sub-module, batch_stats: sum and peak accumulator with load/accumulate/clear controls and abs logic.
- The top level keeps the FSM, beat counter and run counter.

Test Plan (DATA_WIDTH=14, BATCH_SIZE=8, RUNS=3):
- Samples 1..8, sop on beat 1, eop on beat 8, valid continuous -> batch_done one cycle after beat 8; batch_sum=36, batch_peak=8, batch_index=1, frame_error=0.
- 8 beats of -8192 with sink_valid toggling 1/0 every cycle -> batch_sum=-65536, batch_peak=8192; sink_ready low only during the REPORT cycle.
- eop on beat 5 -> no batch_done, frame_error=1. A following good packet of 2s -> batch_sum=16, batch_index=1, frame_error stays 1.
- Three good packets -> after the third batch_done, run_done=1 and sink_ready=0. A restart pulse -> next cycle batch_index=0, run_done=0, sink_ready=1.
- New sop on beat 4 of a packet, then 8 good beats of 3 -> frame_error=1, batch_sum=24, one batch_done only.
- reset_n low mid-packet at beat 4 -> all outputs 0 immediately. After release, a full packet of 1..8 -> batch_sum=36, batch_index=1.
